go_board_renderer: RTL and testbench

- Parametrised successor to the 9x9 Go pixel generator; renders an NxN board (9/13/19) on the 1024x768 XVGA raster.
- Adds a cursor highlight and a synchronous board-memory read port instead of a full board array input.
- Sits between xvga and the VGA output registers.
- Divider-free: cell index and offset come from counters tracked against hcount/vcount.

---
 rtl/go_pkg.sv | 31 +++
 rtl/axis_cell_tracker.sv | 52 +++++
 rtl/go_board_renderer.sv | 236 +++++++++++++++++++++++
 tb/tb_go_board_renderer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/go_pkg.sv
// Shared types, colours and star-point table for the Go board renderer.
package go_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10,
        RSVD  = 2'b11
    } stone_t;

    localparam logic [11:0] COL_BG     = 12'hFF0;
    localparam logic [11:0] COL_LINE   = 12'h000;
    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_WHITE  = 12'hFFF;
    localparam logic [11:0] COL_CURSOR = 12'hF00;

    // Hoshi positions for the three legal board sizes.
    function automatic logic is_star_point(input int n, input int r, input int c);
        logic hit;
        hit = 1'b0;
        if (n == 9) begin
            hit = ((r == 2 || r == 6) && (c == 2 || c == 6)) || (r == 4 && c == 4);
        end else if (n == 13) begin
            hit = ((r == 3 || r == 9) && (c == 3 || c == 9)) || (r == 6 && c == 6);
        end else if (n == 19) begin
            hit = (r == 3 || r == 9 || r == 15) && (c == 3 || c == 9 || c == 15);
        end
        return hit;
    endfunction

endpackage

// File: rtl/axis_cell_tracker.sv
// One axis of the board raster: tracks the cell index and the pixel offset
// inside the cell without any division. Loaded half a pitch before the first
// line, it advances on every step and drops out of range after the last cell.
module axis_cell_tracker #(
    parameter int BOARD_N = 9,
    parameter int PITCH   = 80,
    parameter int IDX_W   = $clog2(BOARD_N + 1),
    parameter int OFF_W   = $clog2(PITCH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic [OFF_W-1:0] off,
    output logic             valid,
    output logic             first,
    output logic             last,
    output logic             adv
);

    localparam logic [OFF_W-1:0] OFF_MAX  = OFF_W'(PITCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BOARD_N - 1);

    assign adv   = step && valid && !load && (off == OFF_MAX);
    assign first = (idx == '0);
    assign last  = (idx == IDX_LAST);

    // Cell index / offset counter with a reload point and an end-of-board stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            off   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            idx   <= '0;
            off   <= '0;
            valid <= 1'b1;
        end else if (step && valid) begin
            if (off == OFF_MAX) begin
                off <= '0;
                idx <= idx + 1'b1;
                if (last) begin
                    valid <= 1'b0;
                end
            end else begin
                off <= off + 1'b1;
            end
        end
    end

endmodule

// File: rtl/go_board_renderer.sv
// NxN Go board pixel generator for the 1024x768 raster. Three-stage pipeline:
// stage 0 cell counters and board address, stage 1 geometry (distance,
// grid, cursor) while the board memory answers, stage 2 colour priority.
// Optional hoshi dots are built only when GO_STAR_POINTS_EN is defined.
module go_board_renderer
    import go_pkg::*;
#(
    parameter int BOARD_N        = 9,
    parameter int PITCH          = 80,
    parameter int STONE_R        = 36,
    parameter int CURSOR_HALF    = 38,
    parameter int DISPLAY_WIDTH  = 1024,
    parameter int DISPLAY_HEIGHT = 768
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [10:0]                         hcount_in,
    input  logic [9:0]                          vcount_in,
    input  logic                                hsync_in,
    input  logic                                vsync_in,
    input  logic                                blank_in,
    output logic [$clog2(BOARD_N*BOARD_N)-1:0]  board_addr,
    input  logic [1:0]                          board_data,
    input  logic                                cursor_en,
    input  logic [4:0]                          cursor_row,
    input  logic [4:0]                          cursor_col,
    output logic                                phsync_out,
    output logic                                pvsync_out,
    output logic                                pblank_out,
    output logic [11:0]                         pixel_out
);

    localparam int LEN    = (BOARD_N - 1) * PITCH;
    localparam int LEFT   = (DISPLAY_WIDTH - LEN) / 2;
    localparam int TOP    = (DISPLAY_HEIGHT - LEN) / 2;
    localparam int HALF   = PITCH / 2;
    localparam int IDX_W  = $clog2(BOARD_N + 1);
    localparam int OFF_W  = $clog2(PITCH);
    localparam int DX_W   = OFF_W + 1;
    localparam int D2_W   = 2 * OFF_W + 1;
    localparam int ADDR_W = $clog2(BOARD_N * BOARD_N);

    localparam logic [10:0]             H_LOAD    = 11'(LEFT - HALF);
    localparam logic [9:0]              V_LOAD    = 10'(TOP - HALF);
    localparam logic signed [DX_W-1:0]  HALF_S    = DX_W'(HALF);
    localparam logic [OFF_W-1:0]        CUR_H     = OFF_W'(CURSOR_HALF);
    localparam logic [D2_W-1:0]         STONE_R2  = D2_W'(STONE_R * STONE_R);
    localparam logic [4:0]              N5        = 5'(BOARD_N);
    localparam logic [ADDR_W-1:0]       ROW_STEP  = ADDR_W'(BOARD_N);

    // Magnitude of a signed cell offset; |offset| never exceeds HALF.
    function automatic logic [OFF_W-1:0] abs_off(input logic signed [DX_W-1:0] v);
        return v[DX_W-1] ? OFF_W'(-v) : OFF_W'(v);
    endfunction

    // ---------------- stage 0: cell counters and board address ----------------
    logic [IDX_W-1:0] col_p0, row_p0;
    logic [OFF_W-1:0] xoff_p0, yoff_p0;
    logic             col_vld_p0, row_vld_p0;
    logic             col_first_p0, col_last_p0, row_first_p0, row_last_p0;
    logic             col_adv, row_adv;
    logic             col_load, row_step, row_load;
    logic [ADDR_W-1:0] row_base;

    assign col_load = (hcount_in == H_LOAD);
    assign row_step = (hcount_in == '0);
    assign row_load = row_step && (vcount_in == V_LOAD);

    axis_cell_tracker #(
        .BOARD_N (BOARD_N),
        .PITCH   (PITCH),
        .IDX_W   (IDX_W),
        .OFF_W   (OFF_W)
    ) u_col (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (col_load),
        .step    (1'b1),
        .idx     (col_p0),
        .off     (xoff_p0),
        .valid   (col_vld_p0),
        .first   (col_first_p0),
        .last    (col_last_p0),
        .adv     (col_adv)
    );

    axis_cell_tracker #(
        .BOARD_N (BOARD_N),
        .PITCH   (PITCH),
        .IDX_W   (IDX_W),
        .OFF_W   (OFF_W)
    ) u_row (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (row_load),
        .step    (row_step),
        .idx     (row_p0),
        .off     (yoff_p0),
        .valid   (row_vld_p0),
        .first   (row_first_p0),
        .last    (row_last_p0),
        .adv     (row_adv)
    );

    // Row-major address kept incrementally: row base steps by N per row, the
    // address reloads from it at the column load point (always after hcount 0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base   <= '0;
            board_addr <= '0;
        end else begin
            if (row_load) begin
                row_base <= '0;
            end else if (row_adv && !row_last_p0) begin
                row_base <= row_base + ROW_STEP;
            end
            if (col_load) begin
                board_addr <= row_base;
            end else if (col_adv && !col_last_p0) begin
                board_addr <= board_addr + 1'b1;
            end
        end
    end

    logic vld_p0;
    assign vld_p0 = col_vld_p0 && row_vld_p0;

    logic signed [DX_W-1:0] dx_c, dy_c;
    logic [OFF_W-1:0]       adx_c, ady_c;
    logic [D2_W-1:0]        d2_c;
    logic                   grid_c, ring_c, cur_c;

    assign dx_c  = $signed({1'b0, xoff_p0}) - HALF_S;
    assign dy_c  = $signed({1'b0, yoff_p0}) - HALF_S;
    assign adx_c = abs_off(dx_c);
    assign ady_c = abs_off(dy_c);
    assign d2_c  = D2_W'(adx_c) * D2_W'(adx_c) + D2_W'(ady_c) * D2_W'(ady_c);

    // Lines stop at the outer intersections: nothing above row 0, below the
    // last row, left of column 0 or right of the last column.
    assign grid_c = ((dx_c == '0) || (dy_c == '0))
                 && !(row_first_p0 && dy_c[DX_W-1])
                 && !(row_last_p0  && (dy_c != '0) && !dy_c[DX_W-1])
                 && !(col_first_p0 && dx_c[DX_W-1])
                 && !(col_last_p0  && (dx_c != '0) && !dx_c[DX_W-1]);

    assign ring_c = ((adx_c == CUR_H) && (ady_c <= CUR_H))
                 || ((ady_c == CUR_H) && (adx_c <= CUR_H));

    assign cur_c = cursor_en && ring_c
                && (cursor_row < N5) && (cursor_col < N5)
                && (cursor_row == 5'(row_p0)) && (cursor_col == 5'(col_p0));

    // ---------------- stage 1: geometry terms, board_data returns ----------------
    logic [D2_W-1:0] d2_p1;
    logic            grid_p1, cur_p1, vld_p1;
`ifdef GO_STAR_POINTS_EN
    logic            star_p1;
`endif

    // Geometry datapath registers (no reset; qualified by vld_p1).
    always_ff @(posedge clk) begin
        d2_p1   <= d2_c;
        grid_p1 <= grid_c;
        cur_p1  <= cur_c;
`ifdef GO_STAR_POINTS_EN
        star_p1 <= is_star_point(BOARD_N, int'(row_p0), int'(col_p0));
`endif
    end

    // ---------------- stage 2: colour priority ----------------
    stone_t      stone_c;
    logic        in_stone_c;
    logic [11:0] pix_c;

    assign stone_c    = stone_t'(board_data);
    assign in_stone_c = (d2_p1 <= STONE_R2);

    // Cursor over stone over hoshi over grid over background.
    always_comb begin
        pix_c = COL_BG;
        if (vld_p1) begin
            if (cur_p1) begin
                pix_c = COL_CURSOR;
            end else if (in_stone_c && stone_c == BLACK) begin
                pix_c = COL_BLACK;
            end else if (in_stone_c && stone_c == WHITE) begin
                pix_c = COL_WHITE;
`ifdef GO_STAR_POINTS_EN
            end else if (star_p1 && d2_p1 <= D2_W'(16)) begin
                pix_c = COL_LINE;
`endif
            end else if (grid_p1) begin
                pix_c = COL_LINE;
            end
        end
    end

    logic hsync_p0, hsync_p1, hsync_p2;
    logic vsync_p0, vsync_p1, vsync_p2;
    logic blank_p0, blank_p1, blank_p2;

    // Valid, sync/blank delay line and the output pixel register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            hsync_p0  <= 1'b1;
            hsync_p1  <= 1'b1;
            hsync_p2  <= 1'b1;
            vsync_p0  <= 1'b1;
            vsync_p1  <= 1'b1;
            vsync_p2  <= 1'b1;
            blank_p0  <= 1'b1;
            blank_p1  <= 1'b1;
            blank_p2  <= 1'b1;
            pixel_out <= 12'h000;
        end else begin
            vld_p1    <= vld_p0;
            hsync_p0  <= hsync_in;
            hsync_p1  <= hsync_p0;
            hsync_p2  <= hsync_p1;
            vsync_p0  <= vsync_in;
            vsync_p1  <= vsync_p0;
            vsync_p2  <= vsync_p1;
            blank_p0  <= blank_in;
            blank_p1  <= blank_p0;
            blank_p2  <= blank_p1;
            pixel_out <= pix_c;
        end
    end

    assign phsync_out = hsync_p2;
    assign pvsync_out = vsync_p2;
    assign pblank_out = blank_p2;

endmodule

// File: tb/tb_go_board_renderer.sv
// Directed bench for go_board_renderer: a 9x9 instance (defaults) and a
// 19x19 instance (PITCH 36) share a compressed raster in which each skipped
// line is a single hcount==0 cycle and rendered lines sweep from hcount 152.
module tb_go_board_renderer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, blank_in;
    logic        cursor_en;
    logic [4:0]  cursor_row, cursor_col;

    logic [6:0]  board_addr9;
    logic [1:0]  board_data9;
    logic        phsync9, pvsync9, pblank9;
    logic [11:0] pixel9;

    logic [8:0]  board_addr19;
    logic [1:0]  board_data19;
    logic        phsync19, pvsync19, pblank19;
    logic [11:0] pixel19;

    logic [1:0]  mem9  [0:80];
    logic [1:0]  mem19 [0:360];

    int          n_vec = 0;
    int          n_bad = 0;
    bit          sync_rand = 1'b1;
    logic [2:0]  hs_h = 3'b111, vs_h = 3'b111, bl_h = 3'b111;

    localparam logic [10:0] IDLE_H = 11'd1100;

`ifdef GO_STAR_POINTS_EN
    localparam logic [11:0] STAR_EXP = 12'h000;
`else
    localparam logic [11:0] STAR_EXP = 12'hFF0;
`endif

    always #5 clk = ~clk;

    go_board_renderer dut9 (
        .clk        (clk),
        .reset_n    (reset_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .board_addr (board_addr9),
        .board_data (board_data9),
        .cursor_en  (cursor_en),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .phsync_out (phsync9),
        .pvsync_out (pvsync9),
        .pblank_out (pblank9),
        .pixel_out  (pixel9)
    );

    go_board_renderer #(
        .BOARD_N     (19),
        .PITCH       (36),
        .STONE_R     (16),
        .CURSOR_HALF (17)
    ) dut19 (
        .clk        (clk),
        .reset_n    (reset_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .board_addr (board_addr19),
        .board_data (board_data19),
        .cursor_en  (cursor_en),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .phsync_out (phsync19),
        .pvsync_out (pvsync19),
        .pblank_out (pblank19),
        .pixel_out  (pixel19)
    );

    // Synchronous board memories, one cycle read latency.
    always_ff @(posedge clk) begin
        board_data9  <= (board_addr9  < 7'd81)  ? mem9[board_addr9]   : 2'b00;
        board_data19 <= (board_addr19 < 9'd361) ? mem19[board_addr19] : 2'b00;
    end

    task automatic chk_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v);
        @(negedge clk);
        hcount_in = h;
        vcount_in = v;
        if (sync_rand) begin
            {hsync_in, vsync_in, blank_in} = 3'($urandom);
        end else begin
            {hsync_in, vsync_in, blank_in} = 3'b000;
        end
        hs_h = {hs_h[1:0], hsync_in};
        vs_h = {vs_h[1:0], vsync_in};
        bl_h = {bl_h[1:0], blank_in};
    endtask

    // Lines vstart..v-1 as single hcount==0 cycles, then line v swept to h.
    task automatic run_to(input int h, input int v, input int vstart);
        for (int vv = vstart; vv < v; vv++) drive(11'd0, 10'(vv));
        drive(11'd0, 10'(v));
        if (h >= 152) begin
            for (int hh = 152; hh <= h; hh++) drive(11'(hh), 10'(v));
        end else begin
            drive(11'(h), 10'(v));
        end
    endtask

    // Two filler cycles, then the target pixel is on the outputs.
    task automatic flush(input int v);
        drive(IDLE_H, 10'(v));
        drive(IDLE_H, 10'(v));
        @(negedge clk);
    endtask

    task automatic check_px(input string tag, input bit sel19, input int h, input int v,
                            input int vstart, input logic [11:0] exp);
        run_to(h, v, vstart);
        flush(v);
        if (sel19) begin
            chk_eq(tag, pixel19, exp);
            chk_eq({tag, "_hs"}, 12'(phsync19), 12'(hs_h[2]));
            chk_eq({tag, "_vs"}, 12'(pvsync19), 12'(vs_h[2]));
            chk_eq({tag, "_bl"}, 12'(pblank19), 12'(bl_h[2]));
        end else begin
            chk_eq(tag, pixel9, exp);
            chk_eq({tag, "_hs"}, 12'(phsync9), 12'(hs_h[2]));
            chk_eq({tag, "_vs"}, 12'(pvsync9), 12'(vs_h[2]));
            chk_eq({tag, "_bl"}, 12'(pblank9), 12'(bl_h[2]));
        end
    endtask

    initial begin
        #50000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 81; i++)  mem9[i]  = 2'b00;
        for (int i = 0; i < 361; i++) mem19[i] = 2'b00;
        reset_n    = 1'b0;
        hcount_in  = IDLE_H;
        vcount_in  = 10'd0;
        {hsync_in, vsync_in, blank_in} = 3'b000;
        cursor_en  = 1'b0;
        cursor_row = 5'd0;
        cursor_col = 5'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_eq("rst_pix",   pixel9, 12'h000);
        chk_eq("rst_hs",    12'(phsync9), 12'h001);
        chk_eq("rst_vs",    12'(pvsync9), 12'h001);
        chk_eq("rst_bl",    12'(pblank9), 12'h001);
        chk_eq("rst_addr",  12'(board_addr9), 12'h000);
        chk_eq("rst_pix19", pixel19, 12'h000);
        reset_n = 1'b1;

        // White stone at (0,0): edge of the disc, then just outside on the row-0 line.
        mem9[0] = 2'b10;
        check_px("white_edge", 1'b0, 228, 64, 0, 12'hFFF);
        check_px("row0_line",  1'b0, 229, 64, 0, 12'h000);

        // Empty board: no line above row 0, corner intersection, open cell.
        mem9[0] = 2'b00;
        check_px("above_top",  1'b0, 192, 50, 0, 12'hFF0);
        check_px("corner",     1'b0, 192, 64, 0, 12'h000);
        check_px("open_cell",  1'b0, 250, 120, 0, 12'hFF0);
        check_px("last_col_x", 1'b0, 832, 64, 0, 12'h000);
        check_px("right_of",   1'b0, 850, 64, 0, 12'hFF0);
        check_px("past_board", 1'b0, 880, 64, 0, 12'hFF0);
        check_px("below_bot",  1'b0, 832, 720, 0, 12'hFF0);

        // Cursor at (4,4) over a black stone.
        mem9[40]   = 2'b01;
        cursor_en  = 1'b1;
        cursor_row = 5'd4;
        cursor_col = 5'd4;
        check_px("cursor_h",   1'b0, 550, 384, 0, 12'hF00);
        check_px("black_in",   1'b0, 548, 384, 0, 12'h000);
        check_px("cursor_v",   1'b0, 512, 346, 0, 12'hF00);
        cursor_col = 5'd5;
        check_px("cursor_oth", 1'b0, 550, 384, 0, 12'h000);
        cursor_en  = 1'b0;
        cursor_col = 5'd4;
        check_px("cursor_off", 1'b0, 550, 384, 0, 12'h000);

        // Diagonal point inside a white stone, then the reserved code.
        mem9[40] = 2'b10;
        check_px("white_diag", 1'b0, 530, 400, 0, 12'hFFF);
        mem9[40] = 2'b11;
        check_px("rsvd_code",  1'b0, 530, 400, 0, 12'hFF0);
        mem9[40] = 2'b00;

        // Hoshi at (2,2), off the grid lines.
        check_px("star_22",    1'b0, 354, 226, 0, STAR_EXP);

        // 19x19 board, pitch 36.
        mem19[360] = 2'b01;
        check_px("n19_corner", 1'b1, 188, 60, 0, 12'h000);
        check_px("n19_black",  1'b1, 836, 708, 0, 12'h000);
        check_px("n19_diag",   1'b1, 845, 717, 0, 12'h000);
        check_px("n19_past",   1'b1, 860, 708, 0, 12'hFF0);

        // Reset pulsed mid-frame with the row counter active.
        sync_rand = 1'b0;
        run_to(400, 300, 0);
        flush(300);
        chk_eq("pre_rst_pix", pixel9, 12'hFF0);
        reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_pix",  pixel9, 12'h000);
        chk_eq("mid_rst_hs",   12'(phsync9), 12'h001);
        chk_eq("mid_rst_vs",   12'(pvsync9), 12'h001);
        chk_eq("mid_rst_bl",   12'(pblank9), 12'h001);
        chk_eq("mid_rst_addr", 12'(board_addr9), 12'h000);
        @(negedge clk);
        reset_n   = 1'b1;
        sync_rand = 1'b1;
        check_px("post_rst_bg",  1'b0, 192, 320, 301, 12'hFF0);
        check_px("next_frame",   1'b0, 192, 320, 0, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
